// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display datapath.
//
// Contents:
//   DISPLAY_DIGITS - number of digits on the display (8)
//   digit_t        - one 4-bit BCD or hex digit
//   bcd_state_t    - converter FSM states {IDLE, SHIFT, DONE}
//   DIGITS_MAX     - largest decimal digit, used for saturation
package display_pkg;

  localparam int DISPLAY_DIGITS = 8;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam digit_t DIGITS_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
//
// Ports:
//   digit_i - accumulator digit before the shift
//   digit_o - corrected digit
//
// Inputs never exceed 9, so the result never exceeds 12 and cannot wrap.
module bcd_digit_adjust
  import display_pkg::*;
(
  input  digit_t digit_i,
  output digit_t digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-digit converter feeding the 8-digit display.
//
// A request is taken through a valid/ready handshake. Decimal requests are
// converted with iterative double-dabble (one input bit per clock); hex
// requests pass the nibbles straight through. The digit outputs and the
// overflow flag change only on the DONE edge, together with the out_valid
// pulse, so the display never sees a partial result.
//
// Ports:
//   clock     - system clock
//   reset     - asynchronous reset, active low
//   in_valid  - request present; in_value / in_hex are valid
//   in_ready  - block can accept a request (high only in IDLE)
//   in_value  - WIDTH-bit value to convert
//   in_hex    - 1 = hex passthrough, 0 = decimal conversion
//   bcds      - DIGITS output digits, digit 0 least significant
//   out_valid - one-cycle pulse when a new result is on bcds
//   overflow  - last decimal result saturated to all nines
//   negative  - (BIN_TO_BCD_SIGNED_EN only) last decimal input was negative
//   dbg_state - current FSM state, for observation only
//
// Handshake: a request transfers on a rising clock edge where in_valid and
// in_ready are both 1. in_valid while in_ready is 0 is ignored, so the
// requester keeps it asserted until the transfer. out_valid has no ready;
// the consumer must take the result in the pulse cycle or read the held
// digits later.
//
// Build option: define BIN_TO_BCD_SIGNED_EN to treat decimal inputs as two's
// complement and add the negative output.
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = DISPLAY_DIGITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_hex,
  output digit_t           bcds [DIGITS-1:0],
  output logic             out_valid,
  output logic             overflow,
`ifdef BIN_TO_BCD_SIGNED_EN
  output logic             negative,
`endif
  output bcd_state_t       dbg_state
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Number of input bits that land in a hex digit; the rest are ignored.
  localparam int HW = (WIDTH < BW) ? WIDTH : BW;

  bcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [BW-1:0]    acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic             hex_q, hex_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcds_q, bcds_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;
`ifdef BIN_TO_BCD_SIGNED_EN
  logic             neg_q, neg_d;
  logic             negative_q, negative_d;
`endif

  logic [BW-1:0]    acc_adj;
  logic [BW-1:0]    hex_flat;
  logic [WIDTH-1:0] load_value;

  // Per-digit +3 correction ahead of each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  always_comb begin
    hex_flat         = '0;
    hex_flat[HW-1:0] = value_q[HW-1:0];
  end

  // Value placed in the shift register on accept. In signed builds the
  // magnitude is taken here so the shift phase is identical in both builds;
  // the most negative value negates to itself, which is its correct
  // unsigned magnitude.
  always_comb begin
    load_value = in_value;
`ifdef BIN_TO_BCD_SIGNED_EN
    if (!in_hex && in_value[WIDTH-1]) begin
      load_value = -in_value;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    hex_d       = hex_q;
    cnt_d       = cnt_q;
    bcds_d      = bcds_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
    neg_d       = neg_q;
    negative_d  = negative_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          value_d = load_value;
          hex_d   = in_hex;
`ifdef BIN_TO_BCD_SIGNED_EN
          neg_d   = !in_hex && in_value[WIDTH-1];
`endif
          if (in_hex) begin
            state_d = DONE;
          end else begin
            acc_d    = '0;
            sticky_d = 1'b0;
            cnt_d    = CW'(WIDTH - 1);
            state_d  = SHIFT;
          end
        end
      end

      SHIFT: begin
        // Shift {acc, value} left by one, using the corrected digits.
        acc_d   = {acc_adj[BW-2:0], value_q[WIDTH-1]};
        value_d = {value_q[WIDTH-2:0], 1'b0};
        if (acc_adj[BW-1]) begin
          sticky_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        out_valid_d = 1'b1;
        state_d     = IDLE;
        if (hex_q) begin
          bcds_d     = hex_flat;
          overflow_d = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
          negative_d = 1'b0;
`endif
        end else begin
          if (sticky_q) begin
            bcds_d     = {DIGITS{DIGITS_MAX}};
            overflow_d = 1'b1;
          end else begin
            bcds_d     = acc_q;
            overflow_d = 1'b0;
          end
`ifdef BIN_TO_BCD_SIGNED_EN
          negative_d = neg_q;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      value_q     <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      hex_q       <= 1'b0;
      cnt_q       <= '0;
      bcds_q      <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
      neg_q       <= 1'b0;
      negative_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      hex_q       <= hex_d;
      cnt_q       <= cnt_d;
      bcds_q      <= bcds_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
`ifdef BIN_TO_BCD_SIGNED_EN
      neg_q       <= neg_d;
      negative_q  <= negative_d;
`endif
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_bcds
    assign bcds[g] = bcds_q[4*g +: 4];
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;
`ifdef BIN_TO_BCD_SIGNED_EN
  assign negative  = negative_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (default 32-bit input, 8 digits).
// Expected digits come from a decimal/hex reference model using plain
// integer arithmetic; results are matched through an expected queue.
module tb_bin_to_bcd_seq;
  import display_pkg::*;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 8;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_value = '0;
  logic             in_hex = 1'b0;
  digit_t           bcds [DIGITS-1:0];
  logic             out_valid;
  logic             overflow;
  bcd_state_t       dbg_state;
`ifdef BIN_TO_BCD_SIGNED_EN
  logic             negative;
`endif

  always #5 clock = ~clock;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_hex    (in_hex),
    .bcds      (bcds),
    .out_valid (out_valid),
    .overflow  (overflow),
`ifdef BIN_TO_BCD_SIGNED_EN
    .negative  (negative),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        exp_ovf_q[$];
  logic        exp_neg_q[$];

  function automatic logic [31:0] flat_bcds();
    logic [31:0] f;
    for (int i = 0; i < DIGITS; i++) f[4*i +: 4] = bcds[i];
    return f;
  endfunction

  // Reference model: decimal digits of the value (or its magnitude in the
  // signed build), saturating above 99,999,999; hex is the raw nibbles.
  function automatic void model(input logic [31:0] v, input logic hex,
                                output logic [31:0] d, output logic ovf,
                                output logic neg);
    longint unsigned mag;
    d   = '0;
    ovf = 1'b0;
    neg = 1'b0;
    if (hex) begin
      d = v;
      return;
    end
    mag = longint'(v);
`ifdef BIN_TO_BCD_SIGNED_EN
    if (v[31]) begin
      neg = 1'b1;
      mag = 64'd4294967296 - longint'(v);
    end
`endif
    if (mag > 64'd99999999) begin
      d   = 32'h99999999;
      ovf = 1'b1;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        d[4*i +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a request and holds it until it transfers; on return we are
  // 1 time unit after the accepting edge. Pushes the expected result.
  task automatic send(input logic [31:0] v, input logic hex, output bit ok);
    logic [31:0] d;
    logic        o;
    logic        n;
    model(v, hex, d, o, n);
    exp_q.push_back(d);
    exp_ovf_q.push_back(o);
    exp_neg_q.push_back(n);
    in_value = v;
    in_hex   = hex;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (in_ready) begin
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_value = $urandom;
        in_hex   = 1'($urandom_range(1, 0));
        ok       = 1'b1;
        return;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output bit got);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        lat = k;
        got = 1'b1;
        return;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++;
    if (flat_bcds() !== 32'h0) begin errors++; $display("FAIL reset_bcds: got %h expected 00000000", flat_bcds()); end
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_decimal_known();
    bit ok, got, bad_ready;
    int lat;
    send(32'd12345678, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dec_accept: got no accept expected accept"); end
    bad_ready = (in_ready !== 1'b0);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin got = 1'b1; lat = k; break; end
      if (in_ready !== 1'b0) bad_ready = 1'b1;
    end
    checks++;
    if (!got || lat != 33) begin errors++; $display("FAIL dec_latency: got %0d expected 33", lat); end
    checks++;
    if (bad_ready) begin errors++; $display("FAIL dec_ready_busy: got in_ready=1 during conversion expected 0"); end
    checks++;
    if (flat_bcds() !== exp_q[0]) begin errors++; $display("FAIL dec_bcds: got %h expected %h", flat_bcds(), exp_q[0]); end
    checks++;
    if (overflow !== exp_ovf_q[0]) begin errors++; $display("FAIL dec_overflow: got %b expected %b", overflow, exp_ovf_q[0]); end
    void'(exp_q.pop_front()); void'(exp_ovf_q.pop_front()); void'(exp_neg_q.pop_front());
    @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL dec_pulse_width: got %b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] vals [3];
    bit ok, got;
    int lat;
    logic [31:0] e;
    logic eo;
    vals[0] = 32'd100000000;
    vals[1] = 32'hFFFFFFFF;
    vals[2] = 32'd99999999;
    for (int i = 0; i < 3; i++) begin
      send(vals[i], 1'b0, ok);
      wait_result(lat, got);
      e  = exp_q.pop_front();
      eo = exp_ovf_q.pop_front();
      void'(exp_neg_q.pop_front());
      checks++;
      if (!ok || !got) begin errors++; $display("FAIL ovf_timeout: got no result expected result for %h", vals[i]); end
      checks++;
      if (flat_bcds() !== e) begin errors++; $display("FAIL ovf_bcds: got %h expected %h (in %h)", flat_bcds(), e, vals[i]); end
      checks++;
      if (overflow !== eo) begin errors++; $display("FAIL ovf_flag: got %b expected %b (in %h)", overflow, eo, vals[i]); end
    end
  endtask

  task automatic test_hex();
    bit ok, got;
    int lat;
    logic [31:0] e;
    logic eo;
    send(32'hDEADBEEF, 1'b1, ok);
    in_value = 32'h0;
    wait_result(lat, got);
    e  = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    void'(exp_neg_q.pop_front());
    checks++;
    if (!ok || !got || lat != 1) begin errors++; $display("FAIL hex_latency: got %0d expected 1", lat); end
    checks++;
    if (flat_bcds() !== e) begin errors++; $display("FAIL hex_bcds: got %h expected %h", flat_bcds(), e); end
    checks++;
    if (overflow !== eo) begin errors++; $display("FAIL hex_overflow: got %b expected %b", overflow, eo); end
  endtask

  task automatic test_zero_hold();
    bit ok, got, changed;
    int lat;
    logic [31:0] e;
    send(32'd0, 1'b0, ok);
    wait_result(lat, got);
    e = exp_q.pop_front();
    void'(exp_ovf_q.pop_front());
    void'(exp_neg_q.pop_front());
    checks++;
    if (!got || flat_bcds() !== e || overflow !== 1'b0) begin
      errors++; $display("FAIL zero_result: got %h/%b expected %h/0", flat_bcds(), overflow, e);
    end
    changed = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      if (flat_bcds() !== e || out_valid !== 1'b0) changed = 1'b1;
    end
    checks++;
    if (changed) begin errors++; $display("FAIL zero_hold: got change while idle expected held %h", e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2;
    logic o, n;
    int  gap;
    bit  first_seen, second_seen, held_bad;
    model(32'd42, 1'b0, e1, o, n);
    model(32'd7, 1'b0, e2, o, n);
    in_value = 32'd42;
    in_hex   = 1'b0;
    in_valid = 1'b1;
    @(posedge clock);     // DUT is idle, this edge accepts 42
    #1;
    in_value = 32'd7;
    gap = 0;
    first_seen = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (in_ready) begin gap = k; break; end
      @(posedge clock);
      #1;
      if (out_valid) begin
        first_seen = 1'b1;
        checks++;
        if (flat_bcds() !== e1) begin errors++; $display("FAIL b2b_first: got %h expected %h", flat_bcds(), e1); end
      end
    end
    @(posedge clock);     // second accept
    #1;
    in_valid = 1'b0;
    checks++;
    if (!first_seen || gap != 34) begin errors++; $display("FAIL b2b_gap: got %0d expected 34", gap); end
    held_bad = 1'b0;
    second_seen = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin second_seen = 1'b1; break; end
      if (flat_bcds() !== e1) held_bad = 1'b1;
    end
    checks++;
    if (held_bad) begin errors++; $display("FAIL b2b_hold: got change before second result expected %h", e1); end
    checks++;
    if (!second_seen || flat_bcds() !== e2) begin errors++; $display("FAIL b2b_second: got %h expected %h", flat_bcds(), e2); end
  endtask

  task automatic test_reset_abort();
    bit ok, got, pulsed;
    int lat;
    logic [31:0] e;
    send(32'd555, 1'b0, ok);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete(); exp_ovf_q.delete(); exp_neg_q.delete();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", in_ready); end
    checks++;
    if (flat_bcds() !== 32'h0 || overflow !== 1'b0) begin errors++; $display("FAIL abort_clear: got %h/%b expected 00000000/0", flat_bcds(), overflow); end
    pulsed = (out_valid !== 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (out_valid !== 1'b0) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin errors++; $display("FAIL abort_pulse: got out_valid=1 expected none"); end
    send(32'd9, 1'b0, ok);
    wait_result(lat, got);
    e = exp_q.pop_front();
    void'(exp_ovf_q.pop_front());
    void'(exp_neg_q.pop_front());
    checks++;
    if (!got || flat_bcds() !== e) begin errors++; $display("FAIL abort_after: got %h expected %h", flat_bcds(), e); end
  endtask

  task automatic test_random();
    bit ok, got;
    int lat;
    logic [31:0] v, e;
    logic hex, eo, en;
    for (int i = 0; i < 24; i++) begin
      hex = 1'($urandom_range(1, 0));
      v   = ($urandom_range(3, 0) == 0) ? $urandom : $urandom_range(99999999, 0);
      send(v, hex, ok);
      wait_result(lat, got);
      e  = exp_q.pop_front();
      eo = exp_ovf_q.pop_front();
      en = exp_neg_q.pop_front();
      checks++;
      if (!ok || !got || lat != (hex ? 1 : 33)) begin errors++; $display("FAIL rand_latency: got %0d expected %0d (in %h hex %b)", lat, hex ? 1 : 33, v, hex); end
      checks++;
      if (flat_bcds() !== e || overflow !== eo) begin
        errors++; $display("FAIL rand_result: got %h/%b expected %h/%b (in %h hex %b)", flat_bcds(), overflow, e, eo, v, hex);
      end
`ifdef BIN_TO_BCD_SIGNED_EN
      checks++;
      if (negative !== en) begin errors++; $display("FAIL rand_negative: got %b expected %b (in %h)", negative, en, v); end
`else
      en = 1'b0;
`endif
      repeat ($urandom_range(2, 0)) @(posedge clock);
      #1;
    end
  endtask

`ifdef BIN_TO_BCD_SIGNED_EN
  task automatic test_signed();
    logic [31:0] vals [3];
    logic        hexs [3];
    bit ok, got;
    int lat;
    logic [31:0] e;
    logic eo, en;
    vals[0] = -32'sd1234;  hexs[0] = 1'b0;
    vals[1] = 32'h80000000; hexs[1] = 1'b0;
    vals[2] = 32'hF0000001; hexs[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(vals[i], hexs[i], ok);
      wait_result(lat, got);
      e  = exp_q.pop_front();
      eo = exp_ovf_q.pop_front();
      en = exp_neg_q.pop_front();
      checks++;
      if (!got || flat_bcds() !== e || overflow !== eo || negative !== en) begin
        errors++;
        $display("FAIL signed: got %h/%b/%b expected %h/%b/%b (in %h)", flat_bcds(), overflow, negative, e, eo, en, vals[i]);
      end
    end
  endtask
`endif

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_decimal_known();
    test_overflow();
    test_hex();
    test_zero_hold();
    test_back_to_back();
    test_reset_abort();
`ifdef BIN_TO_BCD_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
